// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-access stage: load/store codes,
// access FSM states and store lane-formatting helpers.
package mips_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned LT_W   = 4;
    localparam int unsigned ST_W   = 3;
    localparam int unsigned BE_W   = 4;

    localparam logic [LT_W-1:0] LT_LW  = LT_W'(0);
    localparam logic [LT_W-1:0] LT_LH  = LT_W'(1);
    localparam logic [LT_W-1:0] LT_LHU = LT_W'(2);
    localparam logic [LT_W-1:0] LT_LB  = LT_W'(3);
    localparam logic [LT_W-1:0] LT_LBU = LT_W'(4);

    localparam logic [ST_W-1:0] SV_SW = ST_W'(0);
    localparam logic [ST_W-1:0] SV_SH = ST_W'(1);
    localparam logic [ST_W-1:0] SV_SB = ST_W'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } mem_state_e;

    // Byte enables for a store; unknown codes behave as SW.
    function automatic logic [BE_W-1:0] store_be(input logic [ST_W-1:0] st,
                                                 input logic [1:0]      off);
        case (st)
            SV_SH:   store_be = off[1] ? 4'b1100 : 4'b0011;
            SV_SB:   store_be = 4'b0001 << off;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Store data replicated across all lanes so any enabled lane carries it.
    function automatic logic [DATA_W-1:0] store_data(input logic [ST_W-1:0]   st,
                                                     input logic [DATA_W-1:0] wd);
        case (st)
            SV_SH:   store_data = {2{wd[15:0]}};
            SV_SB:   store_data = {4{wd[7:0]}};
            default: store_data = wd;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load formatter: picks the addressed byte/halfword lane of a read word and
// sign- or zero-extends it.
//   rdata_i     : 32-bit word returned by data memory
//   offset_i    : address bits [1:0]
//   load_type_i : load encoding (unknown codes behave as LW)
//   result_o    : formatted 32-bit load value (combinational)
module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        offset_i,
    input  logic [LT_W-1:0]   load_type_i,
    output logic [DATA_W-1:0] result_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        case (offset_i)
            2'd0:    byte_c = rdata_i[7:0];
            2'd1:    byte_c = rdata_i[15:8];
            2'd2:    byte_c = rdata_i[23:16];
            default: byte_c = rdata_i[31:24];
        endcase
        half_c = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (load_type_i)
            LT_LH:   result_o = {{16{half_c[15]}}, half_c};
            LT_LHU:  result_o = {16'h0000, half_c};
            LT_LB:   result_o = {{24{byte_c[7]}}, byte_c};
            LT_LBU:  result_o = {24'h000000, byte_c};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: issues data-memory requests for EX/MEM loads/stores,
// stalls the pipeline while an access is outstanding, formats load data and
// holds the MEM/WB register.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned accesses are
// suppressed and flagged on mem_misalign).
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   EX_MEM_*           : registered EX/MEM controls, address and store data
//   dmem_*             : request/acknowledge data-memory port (outputs registered)
//   mem_stall          : combinational stall to upstream stages
//   mem_misalign       : registered misaligned-access pulse
//   MEM_WB_*           : MEM/WB pipeline register toward write-back
module mem_stage
    import mips_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              EX_MEM_RegWrite,
    input  logic              EX_MEM_MemRead,
    input  logic              EX_MEM_MemWrite,
    input  logic              EX_MEM_MemtoReg,
    input  logic [REG_W-1:0]  EX_MEM_RegWriteA,
    input  logic [DATA_W-1:0] EX_MEM_ALUResult,
    input  logic [DATA_W-1:0] EX_MEM_WriteData,
    input  logic [LT_W-1:0]   EX_MEM_LoadType,
    input  logic [ST_W-1:0]   EX_MEM_SaveType,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [BE_W-1:0]   dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              mem_stall,
    output logic              mem_misalign,
    output logic              MEM_WB_RegWrite,
    output logic [REG_W-1:0]  MEM_WB_RegWriteA,
    output logic [DATA_W-1:0] MEM_WB_Result
);

    mem_state_e        state_q, state_d;
    logic              req_q, req_d, we_q, we_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [DATA_W-1:0] load_q, load_d, load_fmt;
    logic              wb_rw_q, wb_rw_d;
    logic [REG_W-1:0]  wb_ra_q, wb_ra_d;
    logic [DATA_W-1:0] wb_res_q, wb_res_d;
    logic              misalign_q, misalign_d;
    logic              mem_op, misalign_c, stall_c;

    // Read and write together resolve to a write.
    assign mem_op = EX_MEM_MemRead | EX_MEM_MemWrite;

    mem_load_align u_load_align (
        .rdata_i     (dmem_rdata),
        .offset_i    (EX_MEM_ALUResult[1:0]),
        .load_type_i (EX_MEM_LoadType),
        .result_o    (load_fmt)
    );

`ifdef MEM_ALIGN_CHECK_EN
    // Byte accesses and SW are never flagged; LW needs word alignment,
    // halfwords need an even address.
    always_comb begin
        misalign_c = 1'b0;
        if (EX_MEM_MemWrite) begin
            misalign_c = (EX_MEM_SaveType == SV_SH) && EX_MEM_ALUResult[0];
        end else if (EX_MEM_MemRead) begin
            case (EX_MEM_LoadType)
                LT_LH, LT_LHU: misalign_c = EX_MEM_ALUResult[0];
                LT_LB, LT_LBU: misalign_c = 1'b0;
                default:       misalign_c = |EX_MEM_ALUResult[1:0];
            endcase
        end
    end
`else
    assign misalign_c = 1'b0;
`endif

    // Access FSM next-state, request formatting and MEM/WB next values.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        load_d     = load_q;
        misalign_d = 1'b0;
        stall_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_op && !misalign_c) begin
                    stall_c = 1'b1;
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    we_d    = EX_MEM_MemWrite;
                    addr_d  = {EX_MEM_ALUResult[DATA_W-1:2], 2'b00};
                    be_d    = EX_MEM_MemWrite ? store_be(EX_MEM_SaveType, EX_MEM_ALUResult[1:0])
                                              : 4'b1111;
                    wdata_d = EX_MEM_MemWrite ? store_data(EX_MEM_SaveType, EX_MEM_WriteData)
                                              : '0;
                end else if (mem_op) begin
                    misalign_d = 1'b1;
                end
            end
            S_REQ: begin
                stall_c = 1'b1;
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = '0;
                    load_d  = load_fmt;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A stalled cycle injects a bubble into MEM/WB.
        if (stall_c) begin
            wb_rw_d  = 1'b0;
            wb_ra_d  = wb_ra_q;
            wb_res_d = wb_res_q;
        end else begin
            wb_rw_d  = EX_MEM_RegWrite && !misalign_d;
            wb_ra_d  = EX_MEM_RegWriteA;
            wb_res_d = EX_MEM_MemtoReg ? load_q : EX_MEM_ALUResult;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Memory port, captured load data and MEM/WB registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            load_q     <= '0;
            misalign_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_ra_q    <= '0;
            wb_res_q   <= '0;
        end else begin
            req_q      <= req_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            load_q     <= load_d;
            misalign_q <= misalign_d;
            wb_rw_q    <= wb_rw_d;
            wb_ra_q    <= wb_ra_d;
            wb_res_q   <= wb_res_d;
        end
    end

    assign dmem_req         = req_q;
    assign dmem_we          = we_q;
    assign dmem_be          = be_q;
    assign dmem_addr        = addr_q;
    assign dmem_wdata       = wdata_q;
    assign mem_stall        = stall_c;
    assign mem_misalign     = misalign_q;
    assign MEM_WB_RegWrite  = wb_rw_q;
    assign MEM_WB_RegWriteA = wb_ra_q;
    assign MEM_WB_Result    = wb_res_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, sitting directly downstream of the EX/MEM pipeline register. It takes the registered EX/MEM control and data, performs byte/halfword/word loads and stores through a request/acknowledge data-memory port, and stalls the pipeline while an access is outstanding. It also formats load data (lane select, sign/zero extension) and holds the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters:
- none; widths fixed at 32-bit data/address, 5-bit register index.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemtoReg  in  1 each  stage controls
- EX_MEM_RegWriteA  in  5  destination register
- EX_MEM_ALUResult  in  32  effective address / ALU result
- EX_MEM_WriteData  in  32  store data (low bits significant for SB/SH)
- EX_MEM_LoadType  in  4  load encoding
- EX_MEM_SaveType  in  3  store encoding
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address (ALUResult with [1:0] = 0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  single-cycle completion pulse
- mem_stall  out  1  upstream holds EX/MEM and earlier stages while 1
- mem_misalign  out  1  misaligned-access pulse (only with MEM_ALIGN_CHECK_EN)
- MEM_WB_RegWrite  out  1
- MEM_WB_RegWriteA  out  5
- MEM_WB_Result  out  32  formatted load data or ALU result

## Operation
- Encodings: LoadType 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; SaveType 0 SW, 1 SH, 2 SB; other codes treated as LW/SW.
- Little-endian lanes: byte at addr[1:0]=k occupies bits [8k+7:8k].
- Stores: SW be=1111; SH be=0011 (addr[1]=0) / 1100 (addr[1]=1), wdata={2{WriteData[15:0]}}; SB be=1<<addr[1:0], wdata={4{WriteData[7:0]}}.
- Loads: select lane per addr, sign-extend for LH/LB, zero-extend for LHU/LBU.
- FSM states IDLE, REQ, DONE:
  - IDLE: MemRead|MemWrite -> REQ, mem_stall=1; otherwise stay, mem_stall=0, pass-through.
  - REQ: dmem_req=1, addr/be/wdata/we stable; mem_stall=1; on dmem_ack capture formatted rdata -> DONE.
  - DONE: mem_stall=0; MEM/WB loads; -> IDLE.
- MemRead and MemWrite both 1: treated as write.
- MEM/WB update each cycle: mem_stall=1 -> bubble (RegWrite=0, other fields hold); otherwise RegWrite/RegWriteA from EX/MEM, Result = MemtoReg ? captured load data : ALUResult.
- dmem_ack outside REQ ignored.

## Timing
- Reset: state IDLE; dmem_req, dmem_we, dmem_be, mem_stall, mem_misalign, MEM_WB_RegWrite = 0; dmem_addr, dmem_wdata, MEM_WB_RegWriteA, MEM_WB_Result = 0.
- Non-memory op: MEM/WB valid 1 edge after presentation, no stall.
- Memory op with ack on first REQ cycle: mem_stall high 2 cycles, MEM/WB valid at end of the DONE cycle (3rd cycle); each extra wait cycle adds 1.
- mem_stall is combinational from state and EX/MEM inputs; dmem_* outputs are registered.
- Reset asserted mid-REQ: dmem_req drops asynchronously, the access is abandoned, and a later ack is ignored.

## Configuration
- MEM_ALIGN_CHECK_EN defined: LW with addr[1:0]!=0, LH/LHU/SH with addr[0]=1 issue no request and do not stall; mem_misalign=1 for one cycle (registered, with MEM/WB); MEM_WB_RegWrite=0.
- Undefined: no check; mem_misalign tied 0; low address bits beyond lane selection ignored (LW/SW use the word, halfwords use addr[1]).

## Structure
- Package mips_mem_pkg: LoadType/SaveType code constants, FSM state enum.
- Sub-module mem_load_align: combinational lane select and extension (rdata, addr[1:0], LoadType -> 32-bit result).

## Test plan
- SB WriteData=0x000000A5, addr 0x1003, ack after 2 wait cycles -> be=1000, wdata=0xA5A5A5A5, dmem_addr=0x1000, mem_stall high 4 cycles.
- LB addr 0x2001, rdata 0x12348000 -> MEM_WB_Result=0xFFFFFF80; LBU -> 0x00000080; LH addr 0x2002 -> 0x00001234.
- ALU op (MemtoReg=0, ALUResult=0xDEADBEEF, RegWriteA=5) -> MEM_WB_Result=0xDEADBEEF 1 cycle later, no stall.
- Back-to-back LW, LW, each ack on first REQ cycle -> 2 stall cycles each, MEM_WB_RegWrite=0 during stalls, both results correct in order.
- rst asserted in REQ, spurious ack next cycle -> dmem_req=0 immediately, state IDLE, no MEM/WB write.
- With MEM_ALIGN_CHECK_EN: LW addr 0x3002 -> no dmem_req, mem_misalign=1 one cycle, MEM_WB_RegWrite=0.
